// File: rtl/switch_ctrl_pkg.sv
// Shared register map and CTRL bit layout for the slide-switch interrupt controller.
package switch_ctrl_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_MASK = 2'd1,
        REG_EDGE = 2'd2,
        REG_CTRL = 2'd3
    } reg_addr_e;

    localparam int CTRL_DEB_EN   = 0;
    localparam int CTRL_EDGE_SEL = 1;
    localparam int CTRL_RAW_LSB  = 16;

endpackage

// File: rtl/switch_irq_ctrl_if.sv
// Avalon-MM slave bus plus interrupt line for the switch controller.
interface switch_irq_ctrl_if;
    import switch_ctrl_pkg::*;

    logic [1:0]       address;
    logic             chipselect;
    logic             read;
    logic             write;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;
    logic             irq;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/switch_debounce_cell.sv
// One switch bit: 2-FF synchroniser, tick-based stability counter and debounced level flop.
module switch_debounce_cell #(
    parameter int STABLE_N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    input  logic deb_en,
    output logic sync,
    output logic level,
    output logic level_next
);

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_N);

    logic       sync1_r;
    logic       sync2_r;
    logic [3:0] cnt_r;
    logic       data_r;
    logic [3:0] cnt_next_s;
    logic       data_next_s;

    // Synchroniser, counter and debounced level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            cnt_r   <= 4'd0;
            data_r  <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_next_s;
            data_r  <= data_next_s;
        end
    end

    // Next level: bypass follows sync every clk, otherwise a new level needs STABLE_N differing ticks.
    always_comb begin
        cnt_next_s  = cnt_r;
        data_next_s = data_r;
        if (!deb_en) begin
            cnt_next_s  = 4'd0;
            data_next_s = sync2_r;
        end else if (tick) begin
            if (sync2_r != data_r) begin
                if ((cnt_r + 4'd1) == STABLE_LAST) begin
                    cnt_next_s  = 4'd0;
                    data_next_s = sync2_r;
                end else begin
                    cnt_next_s  = cnt_r + 4'd1;
                end
            end else begin
                cnt_next_s = 4'd0;
            end
        end else begin
            cnt_next_s  = cnt_r;
            data_next_s = data_r;
        end
    end

    assign sync       = sync2_r;
    assign level      = data_r;
    assign level_next = data_next_s;

endmodule

// File: rtl/switch_irq_ctrl.sv
// Avalon-MM slide-switch controller: debounced DATA, maskable edge capture and level irq.
module switch_irq_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int TICK_DIV = 50000,
    parameter int STABLE_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch,
    switch_irq_ctrl_if.slave bus
);

    localparam int            TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]    tick_cnt_r;
    logic             tick_s;
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] data_next_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_r;
    logic             deb_en_r;
    logic             edge_sel_r;
    logic             irq_r;
    logic [BUS_W-1:0] readdata_r;
    logic             wr_s;
    logic             rd_s;
    logic [WIDTH-1:0] chg_s;
    logic [WIDTH-1:0] ev_s;
    logic [WIDTH-1:0] clr_s;
    logic [BUS_W-1:0] rd_mux_s;
    logic             unused_s;

    assign wr_s     = bus.chipselect & bus.write;
    assign rd_s     = bus.chipselect & bus.read;
    assign tick_s   = (tick_cnt_r == TICK_LAST);
    assign unused_s = ^bus.writedata;

    // Free-running debounce sample tick divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
        switch_debounce_cell #(
            .STABLE_N (STABLE_N)
        ) u_cell (
            .clk        (clk),
            .reset      (reset),
            .raw        (switch[gi]),
            .tick       (tick_s),
            .deb_en     (deb_en_r),
            .sync       (sync_s[gi]),
            .level      (data_s[gi]),
            .level_next (data_next_s[gi])
        );
    end

    // Edge events from the debounced level and the RW1C clear mask.
    always_comb begin
        chg_s = data_next_s ^ data_s;
        if (edge_sel_r) begin
            ev_s = chg_s & data_next_s;
        end else begin
            ev_s = chg_s;
        end
        if (wr_s && (bus.address == REG_EDGE)) begin
            clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
    end

    // Read-data mux; CTRL also exposes the synchronised raw switches.
    always_comb begin
        rd_mux_s = {BUS_W{1'b0}};
        case (bus.address)
            REG_DATA: rd_mux_s[WIDTH-1:0] = data_s;
            REG_MASK: rd_mux_s[WIDTH-1:0] = mask_r;
            REG_EDGE: rd_mux_s[WIDTH-1:0] = edge_r;
            REG_CTRL: begin
                rd_mux_s[CTRL_DEB_EN]            = deb_en_r;
                rd_mux_s[CTRL_EDGE_SEL]          = edge_sel_r;
                rd_mux_s[CTRL_RAW_LSB +: WIDTH]  = sync_s;
            end
            default:  rd_mux_s = {BUS_W{1'b0}};
        endcase
    end

    // Control/status registers, edge capture (set beats clear) and registered irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r     <= '0;
            edge_r     <= '0;
            deb_en_r   <= 1'b1;
            edge_sel_r <= 1'b0;
            irq_r      <= 1'b0;
            readdata_r <= {BUS_W{1'b0}};
        end else begin
            edge_r <= (edge_r & ~clr_s) | ev_s;
            irq_r  <= |(edge_r & mask_r);
            if (wr_s && (bus.address == REG_MASK)) begin
                mask_r <= bus.writedata[WIDTH-1:0];
            end
            if (wr_s && (bus.address == REG_CTRL)) begin
                deb_en_r   <= bus.writedata[CTRL_DEB_EN];
                edge_sel_r <= bus.writedata[CTRL_EDGE_SEL];
            end
            if (rd_s) begin
                readdata_r <= rd_mux_s;
            end
        end
    end

    assign bus.readdata = readdata_r;
    assign bus.irq      = irq_r;

endmodule

// File: tb/tb_switch_irq_ctrl.sv
// Directed bench for switch_irq_ctrl with TICK_DIV=4, STABLE_N=3, WIDTH=10.
module tb_switch_irq_ctrl;
    import switch_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [9:0] sw;
    int         checks;
    int         errors;
    logic [31:0] rd;

    switch_irq_ctrl_if bus ();

    switch_irq_ctrl #(
        .WIDTH    (10),
        .TICK_DIV (4),
        .STABLE_N (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .switch (sw),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        d              = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, REG_CTRL, 32'h0,        32'h0000_0001};
        vecs[1] = '{1'b0, REG_DATA, 32'h0,        32'h0000_0000};
        vecs[2] = '{1'b0, REG_MASK, 32'h0,        32'h0000_0000};
        vecs[3] = '{1'b0, REG_EDGE, 32'h0,        32'h0000_0000};
        vecs[4] = '{1'b1, REG_MASK, 32'hFFFF_FFFF, 32'h0000_03FF};
        vecs[5] = '{1'b1, REG_DATA, 32'h0000_0123, 32'h0000_0000};
        vecs[6] = '{1'b1, REG_CTRL, 32'h0000_FFFE, 32'h0000_0002};
        vecs[7] = '{1'b1, REG_CTRL, 32'h0000_0001, 32'h0000_0001};
        vecs[8] = '{1'b1, REG_MASK, 32'h0000_0000, 32'h0000_0000};
        vecs[9] = '{1'b1, REG_EDGE, 32'h0000_03FF, 32'h0000_0000};

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sw     = 10'h000;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;

        // 1: reset state and register map
        repeat (3) @(negedge clk);
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", {31'd0, bus.irq}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // 2: debounced rise on alternate bits
        @(negedge clk);
        sw = 10'h2AA;
        repeat (5) @(negedge clk);
        bus_read(REG_DATA, rd);
        check("data_not_early", rd, 32'h0);
        repeat (10) @(negedge clk);
        bus_read(REG_DATA, rd);
        check("data_2aa", rd, 32'h2AA);
        bus_read(REG_EDGE, rd);
        check("edge_2aa", rd, 32'h2AA);
        check("irq_masked", {31'd0, bus.irq}, 32'h0);

        // 3: bounce shorter than STABLE_N ticks is rejected
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sw[0] = ~sw[0];
            repeat (7) @(negedge clk);
        end
        bus_read(REG_DATA, rd);
        check("bounce_data", rd, 32'h2AA);
        bus_read(REG_EDGE, rd);
        check("bounce_edge", rd, 32'h2AA);

        // 4: masked irq, RW1C clear, set-wins collision
        bus_write(REG_EDGE, 32'h3FF);
        bus_write(REG_MASK, 32'h001);
        check("irq_idle", {31'd0, bus.irq}, 32'h0);
        @(negedge clk);
        sw = 10'h2AB;
        begin
            int n;
            n = 0;
            while (!bus.irq && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        check("irq_set", {31'd0, bus.irq}, 32'h1);
        bus_read(REG_EDGE, rd);
        check("edge_bit0", rd, 32'h001);
        bus_write(REG_EDGE, 32'h001);
        check("irq_lag", {31'd0, bus.irq}, 32'h1);
        @(negedge clk);
        check("irq_cleared", {31'd0, bus.irq}, 32'h0);
        bus_write(REG_CTRL, 32'h0);
        @(negedge clk);
        sw = 10'h2AA;
        repeat (6) @(negedge clk);
        check("irq_fall_edge", {31'd0, bus.irq}, 32'h1);
        @(negedge clk);
        sw = 10'h2AB;
        @(negedge clk);
        bus_write(REG_EDGE, 32'h001);
        repeat (2) @(negedge clk);
        check("irq_set_wins", {31'd0, bus.irq}, 32'h1);
        bus_read(REG_EDGE, rd);
        check("edge_set_wins", rd, 32'h001);

        // 5: rising-only edge select
        @(negedge clk);
        sw = 10'h3FF;
        repeat (5) @(negedge clk);
        bus_write(REG_EDGE, 32'h3FF);
        bus_write(REG_CTRL, 32'h3);
        bus_read(REG_EDGE, rd);
        check("edge_clean", rd, 32'h0);
        @(negedge clk);
        sw = 10'h000;
        repeat (20) @(negedge clk);
        bus_read(REG_DATA, rd);
        check("data_fall", rd, 32'h0);
        bus_read(REG_EDGE, rd);
        check("edge_fall_ignored", rd, 32'h0);
        @(negedge clk);
        sw = 10'h155;
        repeat (20) @(negedge clk);
        bus_read(REG_EDGE, rd);
        check("edge_rise_155", rd, 32'h155);
        check("irq_rise", {31'd0, bus.irq}, 32'h1);

        // 6: bypass latency, then reset mid-debounce with a colliding write
        bus_write(REG_CTRL, 32'h0);
        bus_write(REG_EDGE, 32'h3FF);
        @(negedge clk);
        sw = 10'h0F0;
        @(negedge clk);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = REG_DATA;
        @(negedge clk);
        check("bypass_2clk", bus.readdata, 32'h155);
        @(negedge clk);
        check("bypass_3clk", bus.readdata, 32'h0F0);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus_read(REG_EDGE, rd);
        check("bypass_edge", rd, 32'h1A5);
        bus_write(REG_CTRL, 32'h1);
        @(negedge clk);
        sw = 10'h30F;
        repeat (7) @(negedge clk);
        reset          = 1'b1;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = REG_MASK;
        bus.writedata  = 32'h3FF;
        @(negedge clk);
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'd0, bus.irq}, 32'h0);
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus_read(REG_CTRL, rd);
        check("rst_ctrl", rd, 32'h1);
        bus_read(REG_DATA, rd);
        check("rst_data", rd, 32'h0);
        bus_read(REG_MASK, rd);
        check("rst_mask", rd, 32'h0);
        bus_read(REG_EDGE, rd);
        check("rst_edge", rd, 32'h0);
        repeat (20) @(negedge clk);
        bus_read(REG_DATA, rd);
        check("post_rst_data", rd, 32'h30F);
        bus_read(REG_CTRL, rd);
        check("ctrl_raw", rd, 32'h030F_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
